ppu_vram_scheduler: RTL

Schedules every access to the PPU's multiplexed VRAM bus (cartridge CHR plus nametable RAM). It generates the background tile fetch sequence while rendering is enabled, and serialises CPU `$2007` data-port reads and writes when it is not. It sits between the PPU core and the AD/ALE/RD/WR pins that feed the cartridge and `ppuMemory`. It is the single owner of that bus.

---
 rtl/nes_ppu_pkg.sv | 27 ++
 rtl/ppu_vram_scheduler_if.sv | 34 +++
 rtl/ppu_fetch_addr_gen.sv | 44 ++++
 rtl/ppu_vram_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nes_ppu_pkg.sv
// Shared types and constants for the PPU VRAM bus scheduler.
// Contents:
//   sched_state_e  - bus scheduler FSM states
//   fetch_kind_e   - background fetch index within a tile group (NT, AT, PTL, PTH)
//   NT_BASE, AT_BASE, PT_HI_OFS - render address constants
package nes_ppu_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRAddr,
      StRData,
      StCAddr,
      StCData
   } sched_state_e;

   typedef enum logic [1:0] {
      FkNt  = 2'd0,
      FkAt  = 2'd1,
      FkPtl = 2'd2,
      FkPth = 2'd3
   } fetch_kind_e;

   localparam logic [13:0] NT_BASE   = 14'h2000;
   localparam logic [13:0] AT_BASE   = 14'h23C0;
   localparam logic [13:0] PT_HI_OFS = 14'd8;

endpackage

// File: rtl/ppu_vram_scheduler_if.sv
// CPU data-port handshake plus the multiplexed VRAM bus pins.
// Modports:
//   master - the scheduler: drives ack/rdata and all bus pins, samples request and ad_in
//   slave  - the CPU port / memory side: drives request fields and ad_in
interface ppu_vram_scheduler_if #(
   parameter int unsigned ADDR_W = 14
);
   // CPU data port
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              cpu_ack;
   logic [7:0]        cpu_rdata;
   // VRAM bus
   logic [ADDR_W-1:0] ppu_addr;
   logic              ale;
   logic              rd_n;
   logic              wr_n;
   logic [7:0]        ad_out;
   logic              ad_oe;
   logic [7:0]        ad_in;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ad_in,
      output cpu_ack, cpu_rdata, ppu_addr, ale, rd_n, wr_n, ad_out, ad_oe
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, ad_in,
      input  cpu_ack, cpu_rdata, ppu_addr, ale, rd_n, wr_n, ad_out, ad_oe
   );

endinterface

// File: rtl/ppu_fetch_addr_gen.sv
// Combinational background fetch address generator.
// Ports:
//   fk       - fetch kind (NT, AT, PTL, PTH)
//   vaddr    - loopy v: [14:12] fine Y, [11:0] nametable/coarse index
//   bg_table - background pattern table select
//   nt_byte  - nametable byte fetched earlier in this group
//   addr     - resulting VRAM address
module ppu_fetch_addr_gen
   import nes_ppu_pkg::*;
#(
   parameter int unsigned ADDR_W = 14
) (
   input  fetch_kind_e       fk,
   input  logic [14:0]       vaddr,
   input  logic              bg_table,
   input  logic [7:0]        nt_byte,
   output logic [ADDR_W-1:0] addr
);

   logic [13:0] nt_addr;
   logic [13:0] at_addr;
   logic [13:0] ptl_addr;
   logic [13:0] sel_addr;

   assign nt_addr  = NT_BASE | {2'b00, vaddr[11:0]};
   assign at_addr  = AT_BASE | {2'b00, vaddr[11:10], 10'b0} | {8'b0, vaddr[9:7], 3'b0}
                             | {11'b0, vaddr[4:2]};
   // Bit 3 selects the plane, so it stays clear for the low plane.
   assign ptl_addr = {1'b0, bg_table, nt_byte, 1'b0, vaddr[14:12]};

   always_comb begin
      sel_addr = nt_addr;
      unique case (fk)
         FkNt:    sel_addr = nt_addr;
         FkAt:    sel_addr = at_addr;
         FkPtl:   sel_addr = ptl_addr;
         FkPth:   sel_addr = ptl_addr + PT_HI_OFS;
         default: sel_addr = nt_addr;
      endcase
   end

   assign addr = ADDR_W'(sel_addr);

endmodule

// File: rtl/ppu_vram_scheduler.sv
// Sole owner of the PPU VRAM bus. Runs the 8-dot background fetch group
// (NT, AT, PTL, PTH) while rendering is enabled, and otherwise serialises CPU
// data-port accesses. Each access is a two-dot ADDR (ALE) + DATA (strobe) pair.
// Ports:
//   masterClk, rst      - dot clock, synchronous active-high reset
//   render_en           - background rendering enabled (has priority over CPU)
//   vaddr, bg_table     - loopy v and pattern table select, sampled in each ADDR phase
//   bus                 - CPU handshake + AD/ALE/RD/WR pins (master modport)
//   nt_byte .. pt_hi    - last completed tile group
//   tile_valid          - one-dot pulse when the four tile bytes update
//   busy                - FSM not idle
// All outputs are registered: each output register is loaded with the value
// decoded from the state being entered.
module ppu_vram_scheduler
   import nes_ppu_pkg::*;
#(
   parameter int unsigned ADDR_W = 14
) (
   input  logic                        masterClk,
   input  logic                        rst,
   input  logic                        render_en,
   input  logic [14:0]                 vaddr,
   input  logic                        bg_table,
   ppu_vram_scheduler_if.master        bus,
   output logic [7:0]                  nt_byte,
   output logic [7:0]                  at_byte,
   output logic [7:0]                  pt_lo,
   output logic [7:0]                  pt_hi,
   output logic                        tile_valid,
   output logic                        busy
);

   sched_state_e state_q, state_d;
   fetch_kind_e  fk_q, fk_d;

   logic              cmd_we_q;
   logic [7:0]        cmd_wdata_q;
   logic [7:0]        sh_nt_q, sh_at_q, sh_ptl_q;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ale_q, ale_d;
   logic              rd_n_q, rd_n_d;
   logic              wr_n_q, wr_n_d;
   logic [7:0]        ad_out_q, ad_out_d;
   logic              ad_oe_q, ad_oe_d;
   logic              ack_q;
   logic [7:0]        rdata_q;
   logic [7:0]        nt_q, at_q, ptl_q, pth_q;
   logic              tile_valid_q;
   logic              busy_q;

   logic [ADDR_W-1:0] fetch_addr;

   // Address for the render fetch being entered; PTL/PTH use the NT byte of this group.
   ppu_fetch_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .fk       (fk_d),
      .vaddr    (vaddr),
      .bg_table (bg_table),
      .nt_byte  (sh_nt_q),
      .addr     (fetch_addr)
   );

   // Next state and fetch index.
   always_comb begin
      state_d = state_q;
      fk_d    = fk_q;
      unique case (state_q)
         StIdle: begin
            if (render_en) begin
               state_d = StRAddr;
               fk_d    = FkNt;
            end else if (bus.cpu_req && !ack_q) begin
               // The ack dot is ignored so a held request cannot double-fire.
               state_d = StCAddr;
            end
         end
         StRAddr: state_d = StRData;
         StRData: begin
            if (render_en) begin
               state_d = StRAddr;
               fk_d    = fetch_kind_e'(fk_q + 2'd1);
            end else begin
               state_d = StIdle;
               fk_d    = FkNt;
            end
         end
         StCAddr: state_d = StCData;
         StCData: state_d = StIdle;
         default: begin
            state_d = StIdle;
            fk_d    = FkNt;
         end
      endcase
   end

   // Bus pin values for the state being entered.
   always_comb begin
      addr_d   = addr_q;
      ad_out_d = ad_out_q;
      ale_d    = 1'b0;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      ad_oe_d  = 1'b0;
      unique case (state_d)
         StRAddr: begin
            ale_d    = 1'b1;
            addr_d   = fetch_addr;
            ad_out_d = fetch_addr[7:0];
            ad_oe_d  = 1'b1;
         end
         StCAddr: begin
            ale_d    = 1'b1;
            addr_d   = bus.cpu_addr;
            ad_out_d = bus.cpu_addr[7:0];
            ad_oe_d  = 1'b1;
         end
         StRData: rd_n_d = 1'b0;
         StCData: begin
            if (cmd_we_q) begin
               wr_n_d   = 1'b0;
               ad_oe_d  = 1'b1;
               ad_out_d = cmd_wdata_q;
            end else begin
               rd_n_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge masterClk) begin
      if (rst) begin
         state_q      <= StIdle;
         fk_q         <= FkNt;
         cmd_we_q     <= 1'b0;
         cmd_wdata_q  <= 8'h00;
         sh_nt_q      <= 8'h00;
         sh_at_q      <= 8'h00;
         sh_ptl_q     <= 8'h00;
         addr_q       <= '0;
         ale_q        <= 1'b0;
         rd_n_q       <= 1'b1;
         wr_n_q       <= 1'b1;
         ad_out_q     <= 8'h00;
         ad_oe_q      <= 1'b0;
         ack_q        <= 1'b0;
         rdata_q      <= 8'h00;
         nt_q         <= 8'h00;
         at_q         <= 8'h00;
         ptl_q        <= 8'h00;
         pth_q        <= 8'h00;
         tile_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fk_q         <= fk_d;
         addr_q       <= addr_d;
         ale_q        <= ale_d;
         rd_n_q       <= rd_n_d;
         wr_n_q       <= wr_n_d;
         ad_out_q     <= ad_out_d;
         ad_oe_q      <= ad_oe_d;
         busy_q       <= (state_d != StIdle);
         ack_q        <= 1'b0;
         tile_valid_q <= 1'b0;

         if (state_q == StIdle && state_d == StCAddr) begin
            cmd_we_q    <= bus.cpu_we;
            cmd_wdata_q <= bus.cpu_wdata;
         end

         if (state_q == StRData) begin
            unique case (fk_q)
               FkNt:  sh_nt_q  <= bus.ad_in;
               FkAt:  sh_at_q  <= bus.ad_in;
               FkPtl: sh_ptl_q <= bus.ad_in;
               FkPth: begin
                  // Only a completed group is published.
                  nt_q         <= sh_nt_q;
                  at_q         <= sh_at_q;
                  ptl_q        <= sh_ptl_q;
                  pth_q        <= bus.ad_in;
                  tile_valid_q <= 1'b1;
               end
               default: ;
            endcase
         end

         if (state_q == StCData) begin
            ack_q <= 1'b1;
            if (!cmd_we_q) begin
               rdata_q <= bus.ad_in;
            end
         end
      end
   end

   assign bus.ppu_addr  = addr_q;
   assign bus.ale       = ale_q;
   assign bus.rd_n      = rd_n_q;
   assign bus.wr_n      = wr_n_q;
   assign bus.ad_out    = ad_out_q;
   assign bus.ad_oe     = ad_oe_q;
   assign bus.cpu_ack   = ack_q;
   assign bus.cpu_rdata = rdata_q;
   assign nt_byte       = nt_q;
   assign at_byte       = at_q;
   assign pt_lo         = ptl_q;
   assign pt_hi         = pth_q;
   assign tile_valid    = tile_valid_q;
   assign busy          = busy_q;

endmodule
